// File: rtl/sata_trn_pkg.sv
// SATA transport TX arbiter shared types.
// State encoding and frame-owner tags.
package sata_trn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_SEND  = 3'd1,
        ST_DAT_SEND  = 3'd2,
        ST_WAIT      = 3'd3,
        ST_DAT_DRAIN = 3'd4
    } state_t;

    typedef enum logic {
        OWN_CMD = 1'b0,
        OWN_DAT = 1'b1
    } owner_t;

endpackage

// File: rtl/satatrn_cmdbuf.sv
// Command FIS retry buffer.
// Captures one frame, discards oversize frames, replays on demand.
module satatrn_cmdbuf
    import sata_trn_pkg::*;
#(
    parameter int CMD_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fill_en,
    input  logic        s_cmd_valid,
    output logic        s_cmd_ready,
    input  logic        s_cmd_last,
    input  logic [31:0] s_cmd_data,
    input  logic        rd_adv,
    input  logic        rd_rst,
    input  logic        clr,
    output logic        full,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        ovf_err
);

    localparam int AW = $clog2(CMD_WORDS);

    logic [31:0]   mem [CMD_WORDS];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   len;
    logic [AW-1:0] rd_ptr;
    logic          full_q;
    logic          ovf_q;
    logic          err_q;
    logic          wr;

    assign s_cmd_ready = fill_en && !full_q && !reset;
    assign wr          = s_cmd_valid && s_cmd_ready;
    assign full        = full_q;
    assign ovf_err     = err_q;
    assign rd_data     = mem[rd_ptr];
    assign rd_last     = ({1'b0, rd_ptr} == len - (AW+1)'(1));

    // Word storage; contents are only meaningful while full is set.
    always_ff @(posedge clk) begin
        if (wr && !ovf_q) begin
            mem[wr_ptr[AW-1:0]] <= s_cmd_data;
        end
    end

    // Fill pointer, frame latch and oversize-frame discard.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            len    <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (wr) begin
                if (ovf_q) begin
                    if (s_cmd_last) begin
                        ovf_q  <= 1'b0;
                        err_q  <= 1'b1;
                        wr_ptr <= '0;
                    end
                end else if (s_cmd_last) begin
                    full_q <= 1'b1;
                    len    <= wr_ptr + (AW+1)'(1);
                end else if (wr_ptr == (AW+1)'(CMD_WORDS - 1)) begin
                    ovf_q <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                end
            end
        end
    end

    // Replay pointer, rewound for every retransmission.
    always_ff @(posedge clk) begin
        if (reset || clr || rd_rst) begin
            rd_ptr <= '0;
        end else if (rd_adv) begin
            rd_ptr <= rd_ptr + AW'(1);
        end
    end

endmodule

// File: rtl/satatrn_txarb.sv
// SATA transport TX scheduler in front of the link TX stream.
// Arbitrates command vs data FIS, retries commands, watchdogs completion.
module satatrn_txarb
    import sata_trn_pkg::*;
#(
    parameter int CMD_WORDS = 8,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 65535,
    parameter int TW        = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_link_up,
    input  logic        s_cmd_valid,
    output logic        s_cmd_ready,
    input  logic        s_cmd_last,
    input  logic [31:0] s_cmd_data,
    input  logic        s_dat_valid,
    output logic        s_dat_ready,
    input  logic        s_dat_last,
    input  logic [31:0] s_dat_data,
    output logic        o_cmd_done,
    output logic        o_cmd_err,
    output logic        o_dat_done,
    output logic        o_dat_err,
    output logic        o_lnk_valid,
    input  logic        i_lnk_ready,
    output logic [32:0] o_lnk_data,
    output logic        o_lnk_last,
    output logic        o_lnk_abort,
    input  logic        i_lnk_success,
    input  logic        i_lnk_failed,
    output logic        o_busy
);

    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t        state;
    owner_t        owner;
    owner_t        last_grant;
    logic [TW-1:0] wdog;
    logic [RW-1:0] retry;
    logic          cmd_done_q;
    logic          cmd_err_q;
    logic          dat_done_q;
    logic          dat_err_q;
    logic          abort_q;

    logic          fill_en;
    logic          cmd_full;
    logic [31:0]   cmd_rdata;
    logic          cmd_rlast;
    logic          ovf_err;
    logic          rd_adv;
    logic          rd_rst;
    logic          buf_clr;
    logic          in_tx;
    logic          link_down;
    logic          timeout;
    logic          fail_ev;
    logic          succ_ev;
    logic          can_retry;
    logic          own_cmd;
    logic          cmd_beat_last;
    logic          dat_beat_last;

    assign in_tx     = (state == ST_CMD_SEND) || (state == ST_DAT_SEND)
                    || (state == ST_WAIT);
    assign link_down = in_tx && !i_link_up;
    assign timeout   = (state == ST_WAIT) && (wdog == TW'(TIMEOUT - 1));
    assign fail_ev   = in_tx && (link_down || i_lnk_failed || timeout);
    assign succ_ev   = (state == ST_WAIT) && i_lnk_success && !fail_ev;
    assign can_retry = !link_down && (retry < RW'(MAX_RETRY));
    assign own_cmd   = (owner == OWN_CMD);

    assign fill_en = !((state == ST_CMD_SEND)
                    || (state == ST_WAIT && own_cmd));
    assign rd_adv  = (state == ST_CMD_SEND) && o_lnk_valid && i_lnk_ready;
    assign rd_rst  = own_cmd && fail_ev && can_retry;
    assign buf_clr = own_cmd && in_tx
                  && (succ_ev || (fail_ev && !can_retry));

    assign cmd_beat_last = rd_adv && cmd_rlast;
    assign dat_beat_last = (state == ST_DAT_SEND) && s_dat_valid
                        && i_lnk_ready && s_dat_last;

    assign o_busy      = (state != ST_IDLE);
    assign o_cmd_done  = cmd_done_q;
    assign o_cmd_err   = cmd_err_q | ovf_err;
    assign o_dat_done  = dat_done_q;
    assign o_dat_err   = dat_err_q;
    assign o_lnk_abort = abort_q;

    satatrn_cmdbuf #(
        .CMD_WORDS(CMD_WORDS)
    ) u_cmdbuf (
        .clk        (i_clk),
        .reset      (i_reset),
        .fill_en    (fill_en),
        .s_cmd_valid(s_cmd_valid),
        .s_cmd_ready(s_cmd_ready),
        .s_cmd_last (s_cmd_last),
        .s_cmd_data (s_cmd_data),
        .rd_adv     (rd_adv),
        .rd_rst     (rd_rst),
        .clr        (buf_clr),
        .full       (cmd_full),
        .rd_data    (cmd_rdata),
        .rd_last    (cmd_rlast),
        .ovf_err    (ovf_err)
    );

    // Link stream mux; a retry waits out the abort cycle before beat 0.
    always_comb begin
        o_lnk_valid = 1'b0;
        o_lnk_data  = '0;
        o_lnk_last  = 1'b0;
        s_dat_ready = 1'b0;
        case (state)
            ST_CMD_SEND: begin
                o_lnk_valid = !abort_q;
                o_lnk_data  = {1'b0, cmd_rdata};
                o_lnk_last  = cmd_rlast;
            end
            ST_DAT_SEND: begin
                o_lnk_valid = s_dat_valid;
                s_dat_ready = i_lnk_ready;
                o_lnk_data  = {1'b0, s_dat_data};
                o_lnk_last  = s_dat_last;
            end
            ST_DAT_DRAIN: s_dat_ready = 1'b1;
            default: ;
        endcase
    end

    // Arbitration, frame sequencing, watchdog and completion pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_CMD;
            last_grant <= OWN_DAT;
            wdog       <= '0;
            retry      <= '0;
            cmd_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            dat_done_q <= 1'b0;
            dat_err_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            cmd_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            dat_done_q <= 1'b0;
            dat_err_q  <= 1'b0;
            abort_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (i_link_up) begin
                        if (cmd_full
                            && (!s_dat_valid || last_grant == OWN_DAT)) begin
                            state      <= ST_CMD_SEND;
                            owner      <= OWN_CMD;
                            last_grant <= OWN_CMD;
                        end else if (s_dat_valid) begin
                            state      <= ST_DAT_SEND;
                            owner      <= OWN_DAT;
                            last_grant <= OWN_DAT;
                        end
                    end
                end
                ST_DAT_DRAIN: begin
                    if (s_dat_valid && s_dat_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (fail_ev) begin
                        abort_q <= link_down || timeout;
                        wdog    <= '0;
                        if (own_cmd) begin
                            if (can_retry) begin
                                retry <= retry + RW'(1);
                                state <= ST_CMD_SEND;
                            end else begin
                                retry     <= '0;
                                cmd_err_q <= 1'b1;
                                state     <= ST_IDLE;
                            end
                        end else begin
                            dat_err_q <= 1'b1;
                            state <= (state == ST_WAIT || dat_beat_last)
                                   ? ST_IDLE : ST_DAT_DRAIN;
                        end
                    end else if (succ_ev) begin
                        state <= ST_IDLE;
                        if (own_cmd) begin
                            cmd_done_q <= 1'b1;
                            retry      <= '0;
                        end else begin
                            dat_done_q <= 1'b1;
                        end
                    end else if (state == ST_WAIT) begin
                        wdog <= wdog + TW'(1);
                    end else if (cmd_beat_last || dat_beat_last) begin
                        state <= ST_WAIT;
                        wdog  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_satatrn_txarb.sv
// Directed bench for satatrn_txarb.
// Stimulus tasks drive at posedge+2; a monitor logs beats and pulses at negedge.
module tb_satatrn_txarb;

    localparam int CW = 8;
    localparam int MR = 3;
    localparam int TO = 100;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_link_up = 1'b1;
    logic        s_cmd_valid = 1'b0;
    logic        s_cmd_ready;
    logic        s_cmd_last = 1'b0;
    logic [31:0] s_cmd_data = '0;
    logic        s_dat_valid = 1'b0;
    logic        s_dat_ready;
    logic        s_dat_last = 1'b0;
    logic [31:0] s_dat_data = '0;
    logic        o_cmd_done;
    logic        o_cmd_err;
    logic        o_dat_done;
    logic        o_dat_err;
    logic        o_lnk_valid;
    logic        i_lnk_ready = 1'b1;
    logic [32:0] o_lnk_data;
    logic        o_lnk_last;
    logic        o_lnk_abort;
    logic        i_lnk_success = 1'b0;
    logic        i_lnk_failed = 1'b0;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    logic [32:0] beat_q[$];
    logic        last_q[$];
    int nvalid, n_cdone, n_cerr, n_ddone, n_derr, n_abort;
    int dat_sent;
    bit dat_fin;

    satatrn_txarb #(
        .CMD_WORDS(CW), .MAX_RETRY(MR), .TIMEOUT(TO), .TW(16)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_link_up(i_link_up),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_last(s_cmd_last), .s_cmd_data(s_cmd_data),
        .s_dat_valid(s_dat_valid), .s_dat_ready(s_dat_ready),
        .s_dat_last(s_dat_last), .s_dat_data(s_dat_data),
        .o_cmd_done(o_cmd_done), .o_cmd_err(o_cmd_err),
        .o_dat_done(o_dat_done), .o_dat_err(o_dat_err),
        .o_lnk_valid(o_lnk_valid), .i_lnk_ready(i_lnk_ready),
        .o_lnk_data(o_lnk_data), .o_lnk_last(o_lnk_last),
        .o_lnk_abort(o_lnk_abort), .i_lnk_success(i_lnk_success),
        .i_lnk_failed(i_lnk_failed), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_lnk_valid) nvalid++;
            if (o_lnk_valid && i_lnk_ready) begin
                beat_q.push_back(o_lnk_data);
                last_q.push_back(o_lnk_last);
            end
            if (o_cmd_done) n_cdone++;
            if (o_cmd_err) n_cerr++;
            if (o_dat_done) n_ddone++;
            if (o_dat_err) n_derr++;
            if (o_lnk_abort) n_abort++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic clr_mon();
        beat_q.delete();
        last_q.delete();
        nvalid = 0; n_cdone = 0; n_cerr = 0;
        n_ddone = 0; n_derr = 0; n_abort = 0;
        dat_sent = 0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_link_up = 1'b1;
        s_cmd_valid = 1'b0; s_cmd_last = 1'b0;
        s_dat_valid = 1'b0; s_dat_last = 1'b0;
        i_lnk_success = 1'b0; i_lnk_failed = 1'b0;
        tick(2);
        i_reset = 1'b0;
        tick(1);
        clr_mon();
    endtask

    task automatic send_cmd(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bit acc = 0;
            int g = 0;
            s_cmd_valid = 1'b1;
            s_cmd_data = base + 32'(i);
            s_cmd_last = (i == n - 1);
            while (!acc && g < 300) begin
                acc = s_cmd_ready;
                @(posedge i_clk);
                #2;
                g++;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL cmd_accept word %0d ready=0 want 1", i);
            end
        end
        s_cmd_valid = 1'b0;
        s_cmd_last = 1'b0;
    endtask

    task automatic dat_feed(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bit acc = 0;
            int g = 0;
            s_dat_valid = 1'b1;
            s_dat_data = base + 32'(i);
            s_dat_last = (i == n - 1);
            while (!acc && g < 2000) begin
                acc = s_dat_ready;
                @(posedge i_clk);
                #2;
                g++;
            end
            if (acc) dat_sent++;
        end
        s_dat_valid = 1'b0;
        s_dat_last = 1'b0;
        dat_fin = 1'b1;
    endtask

    task automatic wait_last();
        bit ok = 0;
        for (int g = 0; g < 500 && !ok; g++) begin
            #1;
            ok = o_lnk_valid && o_lnk_last && i_lnk_ready;
            @(posedge i_clk);
            #2;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_last no last beat within 500 cycles");
        end
    endtask

    task automatic wait_dat_fin();
        for (int g = 0; g < 3000 && !dat_fin; g++) tick(1);
        checks++;
        if (!dat_fin) begin
            errors++;
            $display("FAIL dat_feed not finished sent=%0d", dat_sent);
        end
    endtask

    task automatic wait_beats(input int n);
        for (int g = 0; g < 500 && beat_q.size() != n; g++) tick(1);
    endtask

    task automatic pulse_succ();
        i_lnk_success = 1'b1;
        tick(1);
        i_lnk_success = 1'b0;
    endtask

    task automatic pulse_fail();
        i_lnk_failed = 1'b1;
        tick(1);
        i_lnk_failed = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick(2);
        #1;
        checks++;
        if ({o_lnk_valid, o_busy, s_cmd_ready, s_dat_ready, o_lnk_data}
            !== 36'd0) begin
            errors++;
            $display("FAIL reset_outs got v%b b%b cr%b dr%b d%h want 0",
                     o_lnk_valid, o_busy, s_cmd_ready, s_dat_ready, o_lnk_data);
        end
        checks++;
        if ({o_cmd_done, o_cmd_err, o_dat_done, o_dat_err, o_lnk_abort}
            !== 5'd0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 00000",
                     {o_cmd_done, o_cmd_err, o_dat_done, o_dat_err, o_lnk_abort});
        end
        i_reset = 1'b0;
        tick(1);
        checks++;
        if (s_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got cr%b b%b want cr1 b0",
                     s_cmd_ready, o_busy);
        end
    endtask

    task automatic test_cmd_basic();
        int nl = 0;
        int bad = 0;
        do_reset();
        send_cmd(5, 32'hA000_0000);
        wait_last();
        tick(9);
        pulse_succ();
        tick(2);
        checks++;
        if (beat_q.size() != 5) begin
            errors++;
            $display("FAIL basic_beats got %0d want 5", beat_q.size());
        end
        for (int i = 0; i < beat_q.size(); i++) begin
            if (beat_q[i] !== {1'b0, 32'hA000_0000 + 32'(i)}) bad++;
            if (last_q[i]) nl++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_data got %0d bad beats want 0", bad);
        end
        checks++;
        if (nl != 1 || last_q.size() != 5 || last_q[4] !== 1'b1) begin
            errors++;
            $display("FAIL basic_last got %0d lasts want 1 on beat 5", nl);
        end
        checks++;
        if (n_cdone != 1 || n_cerr != 0) begin
            errors++;
            $display("FAIL basic_done got done%0d err%0d want 1 0",
                     n_cdone, n_cerr);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got %b want 0", o_busy);
        end
    endtask

    task automatic test_rr();
        do_reset();
        i_link_up = 1'b0;
        send_cmd(3, 32'hC100_0000);
        dat_fin = 1'b0;
        fork
            dat_feed(4, 32'hD100_0000);
        join_none
        i_link_up = 1'b1;
        wait_last();
        pulse_succ();
        i_link_up = 1'b0;
        checks++;
        if (beat_q.size() != 3 || beat_q[0] !== {1'b0, 32'hC100_0000}) begin
            errors++;
            $display("FAIL rr_first got n%0d want cmd 3 beats", beat_q.size());
        end
        send_cmd(2, 32'hC200_0000);
        i_link_up = 1'b1;
        wait_last();
        pulse_succ();
        wait_last();
        pulse_succ();
        tick(2);
        checks++;
        if (beat_q.size() != 9) begin
            errors++;
            $display("FAIL rr_count got %0d want 9", beat_q.size());
        end else begin
            checks++;
            if (beat_q[3] !== {1'b0, 32'hD100_0000}) begin
                errors++;
                $display("FAIL rr_second got %h want 0d1000000", beat_q[3]);
            end
            checks++;
            if (beat_q[7] !== {1'b0, 32'hC200_0000}) begin
                errors++;
                $display("FAIL rr_third got %h want 0c2000000", beat_q[7]);
            end
        end
        checks++;
        if (n_cdone != 2 || n_ddone != 1) begin
            errors++;
            $display("FAIL rr_done got c%0d d%0d want 2 1", n_cdone, n_ddone);
        end
    endtask

    task automatic test_retry();
        int bad = 0;
        do_reset();
        send_cmd(5, 32'h5500_0000);
        for (int r = 0; r < MR + 1; r++) begin
            wait_last();
            tick(3);
            pulse_fail();
        end
        tick(2);
        checks++;
        if (beat_q.size() != 20) begin
            errors++;
            $display("FAIL retry_beats got %0d want 20", beat_q.size());
        end
        for (int k = 0; k < beat_q.size(); k++) begin
            if (beat_q[k] !== {1'b0, 32'h5500_0000 + 32'(k % 5)}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL retry_data got %0d bad want 0", bad);
        end
        checks++;
        if (n_cerr != 1 || n_cdone != 0) begin
            errors++;
            $display("FAIL retry_err got err%0d done%0d want 1 0",
                     n_cerr, n_cdone);
        end
        checks++;
        if (o_busy !== 1'b0 || s_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL retry_idle got b%b cr%b want b0 cr1",
                     o_busy, s_cmd_ready);
        end
    endtask

    task automatic test_dat_drain();
        do_reset();
        dat_fin = 1'b0;
        fork
            dat_feed(100, 32'hB000_0000);
        join_none
        wait_beats(39);
        pulse_fail();
        wait_dat_fin();
        tick(2);
        checks++;
        if (beat_q.size() != 40 || nvalid != 40) begin
            errors++;
            $display("FAIL drain_beats got b%0d v%0d want 40 40",
                     beat_q.size(), nvalid);
        end
        checks++;
        if (dat_sent != 100) begin
            errors++;
            $display("FAIL drain_consumed got %0d want 100", dat_sent);
        end
        checks++;
        if (n_derr != 1 || n_ddone != 0) begin
            errors++;
            $display("FAIL drain_err got err%0d done%0d want 1 0",
                     n_derr, n_ddone);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_busy got %b want 0", o_busy);
        end
    endtask

    task automatic test_timeout();
        int at = -1;
        do_reset();
        send_cmd(5, 32'h7700_0000);
        wait_last();
        for (int c = 0; c < 200 && at < 0; c++) begin
            #1;
            if (o_lnk_abort) at = c;
            @(posedge i_clk);
            #2;
        end
        checks++;
        if (at != TO) begin
            errors++;
            $display("FAIL timeout_cycle got %0d want %0d", at, TO);
        end
        wait_last();
        pulse_succ();
        tick(2);
        checks++;
        if (beat_q.size() != 10 || beat_q[5] !== {1'b0, 32'h7700_0000}) begin
            errors++;
            $display("FAIL timeout_retry got %0d beats want 10", beat_q.size());
        end
        checks++;
        if (n_abort != 1 || n_cdone != 1 || n_cerr != 0) begin
            errors++;
            $display("FAIL timeout_pulses got a%0d d%0d e%0d want 1 1 0",
                     n_abort, n_cdone, n_cerr);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_cmd(10, 32'hF000_0000);
        tick(4);
        checks++;
        if (n_cerr != 1 || nvalid != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf got err%0d valid%0d busy%b want 1 0 0",
                     n_cerr, nvalid, o_busy);
        end
        send_cmd(2, 32'h1234_0000);
        wait_last();
        pulse_succ();
        tick(2);
        checks++;
        if (beat_q.size() != 2 || beat_q[0] !== {1'b0, 32'h1234_0000}) begin
            errors++;
            $display("FAIL ovf_after got %0d beats want 2 from 12340000",
                     beat_q.size());
        end
    endtask

    task automatic test_link_drop();
        do_reset();
        dat_fin = 1'b0;
        fork
            dat_feed(10, 32'hE000_0000);
        join_none
        wait_beats(3);
        i_link_up = 1'b0;
        tick(1);
        #1;
        checks++;
        if (o_lnk_abort !== 1'b1 || o_dat_err !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse got a%b e%b want 1 1",
                     o_lnk_abort, o_dat_err);
        end
        i_link_up = 1'b1;
        wait_dat_fin();
        tick(2);
        checks++;
        if (n_abort != 1 || n_derr != 1 || beat_q.size() != 4) begin
            errors++;
            $display("FAIL drop_totals got a%0d e%0d b%0d want 1 1 4",
                     n_abort, n_derr, beat_q.size());
        end
        checks++;
        if (dat_sent != 10 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_drain got %0d busy%b want 10 0",
                     dat_sent, o_busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_cmd(5, 32'h9900_0000);
        wait_beats(2);
        i_reset = 1'b1;
        tick(1);
        #1;
        checks++;
        if ({o_busy, o_lnk_valid, o_cmd_done, o_cmd_err, o_lnk_abort}
            !== 5'd0) begin
            errors++;
            $display("FAIL rstmid got %b want 00000",
                     {o_busy, o_lnk_valid, o_cmd_done, o_cmd_err, o_lnk_abort});
        end
        i_reset = 1'b0;
        tick(2);
        checks++;
        if (o_busy !== 1'b0 || s_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_buf got b%b cr%b want b0 cr1",
                     o_busy, s_cmd_ready);
        end
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_cmd_basic();
        test_rr();
        test_retry();
        test_dat_drain();
        test_timeout();
        test_overflow();
        test_link_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/satatrn_txarb.md
Name: satatrn_txarb

Overview:
Transport-layer TX scheduler sitting directly in front of the SATA link FSM's abortable transmit stream. It arbitrates between a register/command FIS requester and a DMA data FIS requester, and sequences each frame into the link. It buffers command FIS words so failed command frames can be retried, and runs a completion watchdog that aborts hung frames.

Parameters:
CMD_WORDS, 8, depth of command FIS buffer (power of two, ≥5)
MAX_RETRY, 3, retransmissions of a failed command FIS before error
TIMEOUT, 65535, cycles allowed in WAIT before link abort
TW, 16, watchdog counter width (must hold TIMEOUT)

Ports:
i_clk  in  1  clock (link TX clock)
i_reset  in  1  synchronous active-high reset
i_link_up  in  1  link ready/synced (link FSM o_ready)
s_cmd_valid/s_cmd_ready/s_cmd_last  in/out/in  1  command FIS stream
s_cmd_data  in  32  command word
s_dat_valid/s_dat_ready/s_dat_last  in/out/in  1  data FIS stream
s_dat_data  in  32  data word
o_cmd_done, o_cmd_err, o_dat_done, o_dat_err  out  1  one-cycle completion pulses
o_lnk_valid  out  1  to link s_valid
i_lnk_ready  in  1  from link s_ready
o_lnk_data  out  33  to link s_data; bit 32 always 0
o_lnk_last  out  1  to link s_last
o_lnk_abort  out  1  to link s_abort, one-cycle pulse
i_lnk_success, i_lnk_failed  in  1  link completion pulses
o_busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, all outputs 0, buffer pointers 0, retry count 0, rr pointer favours CMD next.
- Command fill is independent of arbitration: s_cmd_ready = 1 while buffer not yet holding a complete frame and state != CMD_SEND/CMD_WAIT. Words are written at wr_ptr. On last: frame latched (len = wr_ptr+1), ready drops.
- Overflow: CMD_WORDS words without last → discard further words until last, then pulse o_cmd_err, clear buffer.
- IDLE grant requires i_link_up. Candidates: CMD (complete frame buffered), DAT (s_dat_valid). Both present → grant the one not granted last time; update rr on grant. Grant takes 1 cycle; the send starts on the next cycle.
- CMD_SEND: o_lnk_valid = 1, o_lnk_data = {0,buf[rd_ptr]}, o_lnk_last = (rd_ptr == len-1). rd_ptr advances on i_lnk_ready. After last beat → WAIT.
- DAT_SEND: combinational pass-through: o_lnk_valid = s_dat_valid, s_dat_ready = i_lnk_ready, data/last forwarded. After last beat → WAIT. s_dat_ready = 0 in every other state except DAT_DRAIN.
- WAIT: watchdog counts from 0; o_lnk_valid = 0.
  - i_lnk_success → done pulse for the owner, IDLE. For CMD the buffer is cleared and retry = 0.
  - i_lnk_failed → failure handling.
  - Counter reaches TIMEOUT → o_lnk_abort pulse, then failure handling.
- Failure handling:
  - CMD with retry < MAX_RETRY → retry++, rd_ptr = 0, back to CMD_SEND. Buffer is kept.
  - CMD exhausted → o_cmd_err, clear buffer, IDLE.
  - DAT → o_dat_err. Go to IDLE if the last beat has already passed, else DAT_DRAIN.
- i_lnk_failed during a SEND state (link saw SYNC mid-frame) takes the same failure path immediately.
- DAT_DRAIN: s_dat_ready = 1, o_lnk_valid = 0, words discarded until last beat, then IDLE.
- Simultaneous i_lnk_success and i_lnk_failed → failed wins.
- !i_link_up in any non-IDLE state → o_lnk_abort pulse, then failure handling with no retry (CMD and DAT both report err).
- Reset mid-frame → IDLE next cycle with no pulses; partial command buffer discarded.
- Link-level collisions are absorbed by the link FSM, which keeps o_lnk_valid held; the arbiter simply waits.

Decomposition:
- Shared package (sata_trn_pkg): TX arbiter state encoding (IDLE, CMD_SEND, DAT_SEND, WAIT, DAT_DRAIN), owner enum {CMD, DAT}.
- One natural sub-module: satatrn_cmdbuf (fill/overflow/read-pointer logic for the command buffer).

Test Plan:
- 5-word cmd FIS, link ready every cycle, success 10 cycles after last → 5 beats, last on beat 5, o_cmd_done one cycle, o_busy low after.
- cmd and dat both pending from reset → cmd sent first; next simultaneous pending → dat sent first (rr alternation).
- cmd FIS with i_lnk_failed after each send, MAX_RETRY=3 → 4 identical transmissions, then o_cmd_err, never o_cmd_done.
- 100-word data FIS, i_lnk_failed at beat 40 → o_dat_err once, remaining 60 words drained with o_lnk_valid=0, then IDLE.
- TIMEOUT=100, no completion → o_lnk_abort exactly at cycle 100 of WAIT; cmd retried.
- 10-word cmd into CMD_WORDS=8 → words 9-10 discarded, o_cmd_err, nothing sent; i_link_up drop mid-DAT_SEND → abort pulse, o_dat_err.
